mole_scheduler: RTL
===================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter NUM_MOLES, default 5: number of mole positions/LEDs/buttons (2..8).
REQ-002 Parameter GAME_TICKS, default 60: game length in tick pulses (1..127).
REQ-003 Parameter MOLE_TICKS, default 2: mole lifetime in tick pulses (1..15).
REQ-004 Parameter GAP_TICKS, default 1: blank interval between moles in tick pulses (1..15).
REQ-005 clock  input  1  system clock (100 MHz); all state SHALL change only on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; one clock; no other clock domains.
REQ-007 start  input  1  debounced single-cycle start pulse.
REQ-008 tick  input  1  single-cycle enable pulse from the 1 Hz divider, synchronous to clock.
REQ-009 hit_btn  input  NUM_MOLES  debounced single-cycle mole button pulses.
REQ-010 rand  input  8  free-running pseudo-random value; sampled only when a mole is placed.
REQ-011 mole_led  output  NUM_MOLES  registered one-hot active mole, or all zero.
REQ-012 hit_pulse  output  1  registered single-cycle pulse per scored hit (drives score counter).
REQ-013 miss_pulse  output  1  registered single-cycle pulse per expired, unhit mole.
REQ-014 time_left  output  7  registered remaining game ticks.
REQ-015 game_active  output  1  high in GAP and SHOW states.
REQ-016 game_over  output  1  high in DONE state.

Function
REQ-017 FSM states SHALL be IDLE, GAP, SHOW, DONE, with reset state IDLE.
REQ-018 IDLE/DONE, start=1: next state GAP; time_left <= GAME_TICKS; gap counter <= GAP_TICKS; mole_led <= 0.
REQ-019 GAP/SHOW, start: ignored (no restart mid-game).
REQ-020 GAP/SHOW, each tick: time_left decrements by 1.
REQ-021 GAP/SHOW, tick with time_left==1: time_left becomes 0, mole_led clears, state goes to DONE; this overrides every other transition in that cycle.
REQ-022 GAP, tick with gap counter==1: enter SHOW.
- Mole index idx = rand mod NUM_MOLES.
- If idx equals the previous mole index, use (idx+1) mod NUM_MOLES instead.
- mole_led <= one-hot(idx); life counter <= MOLE_TICKS.
REQ-023 GAP, other ticks: gap counter decrements.
REQ-024 SHOW, (hit_btn & mole_led) != 0:
- hit_pulse=1 on the next cycle;
- mole_led clears; gap counter reloads GAP_TICKS; state goes to GAP.
REQ-025 SHOW, hit_btn bits not matching mole_led: ignored (no pulse, no state change).
REQ-026 SHOW, tick with life counter==1 and no matching hit that cycle:
- miss_pulse=1 on the next cycle;
- mole_led clears; state goes to GAP with gap counter reloaded.
REQ-027 SHOW, other ticks: life counter decrements.
REQ-028 Matching hit and tick in the same cycle: hit wins.
- hit_pulse only, no miss_pulse;
- time_left still decrements.
- If that tick ends the game (REQ-021), hit_pulse is still issued and the state goes to DONE.
REQ-029 hit_btn outside SHOW: no effect.
REQ-030 hit_pulse and miss_pulse SHALL never be high in the same cycle; each is at most one cycle per mole.
REQ-031 Output latency: every output reflects the event one clock after the event's input sample.
REQ-032 mole_led SHALL be zero or one-hot at all times.
REQ-033 time_left SHALL never wrap below 0.
REQ-034 DONE SHALL hold time_left=0, mole_led=0 and game_over=1 until start.

Reset
REQ-035 reset=0 SHALL immediately (asynchronously) force:
- state IDLE;
- mole_led, hit_pulse, miss_pulse, time_left, game_active, game_over all 0;
- all internal counters 0;
- previous mole index 0.
REQ-036 Reset asserted mid-game SHALL abort the game with no pending pulse emitted after release.
REQ-037 After reset release, the block SHALL stay in IDLE until start.

Verification (NUM_MOLES=5, GAME_TICKS=10, MOLE_TICKS=2, GAP_TICKS=1)
REQ-038 Normal hit: start, tick with rand=8 -> mole_led=5'b01000; then hit_btn=5'b01000 -> one-cycle hit_pulse, mole_led=0, state GAP.
REQ-039 Miss: mole shown, two ticks with no button -> miss_pulse exactly one cycle, mole_led=0, time_left decremented twice.
REQ-040 Same cycle, no repeat: hit_btn match coincident with tick -> hit_pulse=1, miss_pulse=0; next mole with rand giving the same idx -> mole at idx+1 mod 5.
REQ-041 Game end: 10 ticks after start -> time_left=0, game_over=1, game_active=0, mole_led=0; further ticks and buttons are ignored; start restarts with time_left=10.
REQ-042 Reset mid-SHOW: reset=0 asynchronously clears all outputs within the same cycle; start then does nothing while reset=0; after release, behaviour matches power-up.
REQ-043 Wrong button and mid-game start: hit_btn=5'b00001 while mole_led=5'b10000 -> no pulse; start pulse in GAP -> time_left unchanged.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler
// Whack-a-mole game sequencer. A start pulse begins a game of GAME_TICKS tick
// pulses. The game alternates between a blank gap (GAP_TICKS ticks) and a
// single lit mole (up to MOLE_TICKS ticks). A matching button press scores a
// hit; a mole that times out scores a miss. The game ends when the tick
// budget is exhausted and remains finished until the next start.
//
// Ports
//   clock        system clock, all state changes on its rising edge
//   reset        asynchronous active-low reset
//   start        single-cycle start pulse (ignored while a game runs)
//   tick         single-cycle 1 Hz enable pulse
//   hit_btn      per-mole single-cycle button pulses
//   rand_value   free-running pseudo-random byte, sampled when a mole is placed
//   mole_led     one-hot lit mole, or all zero
//   hit_pulse    one-cycle pulse per scored hit
//   miss_pulse   one-cycle pulse per expired, unhit mole
//   time_left    remaining game ticks
//   game_active  high while a game is running (gap or mole shown)
//   game_over    high once a game has finished, until the next start
module mole_scheduler #(
    parameter int NUM_MOLES  = 5,
    parameter int GAME_TICKS = 60,
    parameter int MOLE_TICKS = 2,
    parameter int GAP_TICKS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic [NUM_MOLES-1:0] hit_btn,
    input  logic [7:0]           rand_value,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [6:0]           time_left,
    output logic                 game_active,
    output logic                 game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_r;
    logic [3:0] gap_cnt_r;
    logic [3:0] life_cnt_r;
    logic [2:0] prev_idx_r;

    logic [2:0] raw_idx_s;
    logic [2:0] idx_s;
    logic       hit_match_s;
    logic       last_tick_s;

    // One-hot LED pattern for a mole index.
    function automatic logic [NUM_MOLES-1:0] to_onehot(input logic [2:0] idx);
        to_onehot = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next mole position: random index, bumped by one when it would repeat.
    always_comb begin
        raw_idx_s = 3'(rand_value % 8'(NUM_MOLES));
        if (raw_idx_s == prev_idx_r) begin
            if (raw_idx_s == 3'(NUM_MOLES - 1)) begin
                idx_s = 3'd0;
            end else begin
                idx_s = raw_idx_s + 3'd1;
            end
        end else begin
            idx_s = raw_idx_s;
        end
    end

    // Event decode: a press on the lit mole, and the tick that ends the game.
    always_comb begin
        hit_match_s = |(hit_btn & mole_led);
        last_tick_s = tick && (time_left == 7'd1);
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            gap_cnt_r   <= 4'd0;
            life_cnt_r  <= 4'd0;
            prev_idx_r  <= 3'd0;
            mole_led    <= {NUM_MOLES{1'b0}};
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            time_left   <= 7'd0;
            game_active <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            // The game clock runs in both in-game states; never below zero.
            if ((state_r == ST_GAP || state_r == ST_SHOW) && tick && (time_left != 7'd0)) begin
                time_left <= time_left - 7'd1;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= ST_GAP;
                        time_left   <= 7'(GAME_TICKS);
                        gap_cnt_r   <= 4'(GAP_TICKS);
                        mole_led    <= {NUM_MOLES{1'b0}};
                        game_active <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (last_tick_s) begin
                        state_r     <= ST_DONE;
                        mole_led    <= {NUM_MOLES{1'b0}};
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                    end else if (tick) begin
                        if (gap_cnt_r == 4'd1) begin
                            state_r    <= ST_SHOW;
                            mole_led   <= to_onehot(idx_s);
                            prev_idx_r <= idx_s;
                            life_cnt_r <= 4'(MOLE_TICKS);
                        end else begin
                            gap_cnt_r <= gap_cnt_r - 4'd1;
                        end
                    end
                end
                ST_SHOW: begin
                    if (last_tick_s) begin
                        // Game end wins, but a coincident hit still scores.
                        hit_pulse   <= hit_match_s;
                        state_r     <= ST_DONE;
                        mole_led    <= {NUM_MOLES{1'b0}};
                        game_active <= 1'b0;
                        game_over   <= 1'b1;
                    end else if (hit_match_s) begin
                        hit_pulse <= 1'b1;
                        state_r   <= ST_GAP;
                        mole_led  <= {NUM_MOLES{1'b0}};
                        gap_cnt_r <= 4'(GAP_TICKS);
                    end else if (tick) begin
                        if (life_cnt_r == 4'd1) begin
                            miss_pulse <= 1'b1;
                            state_r    <= ST_GAP;
                            mole_led   <= {NUM_MOLES{1'b0}};
                            gap_cnt_r  <= 4'(GAP_TICKS);
                        end else begin
                            life_cnt_r <= life_cnt_r - 4'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mole_led    <= {NUM_MOLES{1'b0}};
                    time_left   <= 7'd0;
                    game_active <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule
